lcd_write_scheduler: RTL and testbench

Sequencer and arbiter for the shared HD44780-style character LCD. After reset it runs the LCD power-up wait and init command sequence by itself. It then accepts byte writes from two requesters through valid/ready handshakes: requester 0 is the ALU operand/answer formatter, requester 1 is the label/message writer. It grants them round-robin and generates the rs/rw/e/data bus timing for each write. It replaces ad-hoc LCD strobing in the top level, so clients only present bytes.

---
 rtl/lcd_write_scheduler_if.sv | 39 +++
 rtl/lcd_write_scheduler.sv | 165 ++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_scheduler_if.sv
// Requester handshakes plus LCD bus for lcd_write_scheduler.
//   master : requester side (drives valid/rs/data, observes ready and bus status)
//   slave  : scheduler side (drives readies, status, LCD control/data lines)
// Signals:
//   reqN_valid/reqN_rs/reqN_data : byte offered by requester N (rs 0=command, 1=data)
//   reqN_ready                   : byte taken this cycle when valid is high
//   busy, init_done, grant       : scheduler status
//   rs, rw, e, lcd_data          : HD44780 bus
interface lcd_write_scheduler_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       busy;
  logic       init_done;
  logic       grant;
  logic       rs;
  logic       rw;
  logic       e;
  logic [7:0] lcd_data;

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready,
    input  busy, init_done, grant, rs, rw, e, lcd_data
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready,
    output busy, init_done, grant, rs, rw, e, lcd_data
  );
endinterface

// File: rtl/lcd_write_scheduler.sv
// Power-up sequencer and two-requester round-robin arbiter for an HD44780 LCD.
// After reset it waits PWRUP_US, issues the four init commands, then serves
// byte writes from requester 0/1, generating rs/rw/e/lcd_data timing.
// Ports:
//   CLK      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : requester handshakes, status and LCD bus (slave modport)
module lcd_write_scheduler #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned PWRUP_US   = 50000,
  parameter int unsigned WRITE_US   = 50,
  parameter int unsigned CLEAR_US   = 2000
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  lcd_write_scheduler_if.slave  bus
);

  localparam int unsigned PWRUP_CYC = PWRUP_US * CLK_PER_US;
  localparam int unsigned WRITE_CYC = WRITE_US * CLK_PER_US;
  localparam int unsigned CLEAR_CYC = CLEAR_US * CLK_PER_US;
  localparam int unsigned E_ON      = CLK_PER_US;
  localparam int unsigned E_OFF     = 14 * CLK_PER_US;
  localparam int unsigned MAX_A     = (PWRUP_CYC > CLEAR_CYC) ? PWRUP_CYC : CLEAR_CYC;
  localparam int unsigned MAX_B     = (WRITE_CYC > E_OFF) ? WRITE_CYC : E_OFF;
  localparam int unsigned MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_CLOG  = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W     = (CNT_CLOG < 1) ? 1 : CNT_CLOG;

  // Init commands are loaded on the edge that leaves PWRUP or ends the
  // previous init write, so the init step itself costs no cycle.
  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_WRITE = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               init_done_q, init_done_d;
  logic               grant_q, grant_d;
  logic [1:0]         init_pos_q, init_pos_d;
  logic               win_c;
  logic               req0_ready_c;
  logic               req1_ready_c;
  logic               wr_long_c;
  logic [CNT_W-1:0]   wr_last_c;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0E;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Clear/home commands need the long settle time
  assign wr_long_c = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign wr_last_c = wr_long_c ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(WRITE_CYC - 1);

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      e_q         <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      grant_q     <= 1'b0;
      init_pos_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      grant_q     <= grant_d;
      init_pos_q  <= init_pos_d;
    end
  end

  // Next-state, arbitration and registered-output next values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    rs_d         = rs_q;
    data_d       = data_q;
    grant_d      = grant_q;
    init_pos_d   = init_pos_q;
    init_done_d  = init_done_q;
    win_c        = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    e_d          = 1'b0;
    busy_d       = 1'b1;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          state_d    = ST_WRITE;
          cnt_d      = '0;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
          init_pos_d = 2'd0;
        end
      end
      ST_WRITE: begin
        if (cnt_q == wr_last_c) begin
          cnt_d = '0;
          if (init_done_q || (init_pos_q == 2'd3)) begin
            state_d     = ST_IDLE;
            rs_d        = 1'b0;
            data_d      = 8'h00;
            init_done_d = 1'b1;
          end else begin
            init_pos_d = init_pos_q + 2'd1;
            rs_d       = 1'b0;
            data_d     = init_cmd(init_pos_q + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        // Lone requester wins; on contention the one not granted last wins
        win_c = (bus.req0_valid && bus.req1_valid) ? ~grant_q : bus.req1_valid;
        if (bus.req0_valid || bus.req1_valid) begin
          req0_ready_c = ~win_c;
          req1_ready_c = win_c;
          state_d      = ST_WRITE;
          grant_d      = win_c;
          rs_d         = win_c ? bus.req1_rs   : bus.req0_rs;
          data_d       = win_c ? bus.req1_data : bus.req0_data;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase

    // e window is measured from the first cycle of each write
    e_d    = (state_d == ST_WRITE) && (cnt_d >= CNT_W'(E_ON)) && (cnt_d < CNT_W'(E_OFF));
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.busy       = busy_q;
  assign bus.init_done  = init_done_q;
  assign bus.grant      = grant_q;
  assign bus.rs         = rs_q;
  assign bus.rw         = 1'b0;
  assign bus.e          = e_q;
  assign bus.lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Self-checking bench for lcd_write_scheduler: a time-schedule model of the
// LCD writes is compared against the DUT every cycle, plus directed scenarios
// with hand-computed expectations and a randomized two-requester phase.
module tb_lcd_write_scheduler;

  localparam int CPU   = 2;
  localparam int PUS   = 10;
  localparam int WUS   = 5;
  localparam int CUS   = 20;
  localparam int PC    = PUS * CPU;
  localparam int WC    = WUS * CPU;
  localparam int CC    = CUS * CPU;
  localparam int E_ON  = CPU;
  localparam int E_OFF = 14 * CPU;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_write_scheduler_if bus ();

  lcd_write_scheduler #(
    .CLK_PER_US (CPU),
    .PWRUP_US   (PUS),
    .WRITE_US   (WUS),
    .CLEAR_US   (CUS)
  ) dut (
    .CLK     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int         start;
    int         len;
    bit         rs;
    logic [7:0] data;
  } wr_t;

  // Model: list of scheduled writes on an absolute cycle timeline
  wr_t  mq[$];
  int   t;
  int   idle_from;
  int   init_end;
  bit   m_grant;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_both = 0;
  int   n_hs;
  int   hs0_t, hs1_t;
  bit   hs0, hs1;
  int   first_idle_t, init_done_t;
  bit   e_prev;
  int   e_len;
  int   e_hi_len[$];
  logic [7:0] e_data[$];

  bit         pend0, pend1, rnd_mode;
  bit         r0, r1;
  logic [7:0] d0, d1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic int wr_len(input bit rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CC : WC;
  endfunction

  task automatic m_reset();
    logic [7:0] cmds [4];
    wr_t w;
    int  s;
    cmds = '{8'h38, 8'h0E, 8'h01, 8'h06};
    mq.delete();
    s = PC;
    for (int i = 0; i < 4; i++) begin
      w.start = s; w.rs = 1'b0; w.data = cmds[i]; w.len = wr_len(1'b0, cmds[i]);
      mq.push_back(w);
      s += w.len;
    end
    idle_from    = s;
    init_end     = s;
    t            = 0;
    m_grant      = 1'b0;
    e_prev       = 1'b0;
    e_len        = 0;
    e_data.delete();
    e_hi_len.delete();
    first_idle_t = -1;
    init_done_t  = -1;
    n_hs         = 0;
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin : cmp
    bit v0, v1, xr0, xr1, xe, xrs, xbusy, xinit, w;
    logic [7:0] xd;
    int off;
    wr_t nw;
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (!rst_n) begin
      chk("rst_busy",   int'(bus.busy),       1);
      chk("rst_init",   int'(bus.init_done),  0);
      chk("rst_grant",  int'(bus.grant),      0);
      chk("rst_e",      int'(bus.e),          0);
      chk("rst_rs",     int'(bus.rs),         0);
      chk("rst_rw",     int'(bus.rw),         0);
      chk("rst_data",   int'(bus.lcd_data),   0);
      chk("rst_ready0", int'(bus.req0_ready), 0);
      chk("rst_ready1", int'(bus.req1_ready), 0);
      m_reset();
    end else begin
      while (mq.size() > 0 && t >= mq[0].start + mq[0].len) void'(mq.pop_front());
      xe = 1'b0; xrs = 1'b0; xd = 8'h00;
      if (mq.size() > 0 && t >= mq[0].start) begin
        off = t - mq[0].start;
        xrs = mq[0].rs;
        xd  = mq[0].data;
        xe  = (off >= E_ON) && (off < E_OFF);
      end
      xbusy = (t < idle_from);
      xinit = (t >= init_end);
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      xr0 = 1'b0; xr1 = 1'b0;
      if (!xbusy) begin
        if (v0 && v1) begin xr0 = m_grant; xr1 = !m_grant; end
        else begin xr0 = v0; xr1 = v1; end
      end
      chk("e",        int'(bus.e),          int'(xe));
      chk("rs",       int'(bus.rs),         int'(xrs));
      chk("rw",       int'(bus.rw),         0);
      chk("lcd_data", int'(bus.lcd_data),   int'(xd));
      chk("busy",     int'(bus.busy),       int'(xbusy));
      chk("init",     int'(bus.init_done),  int'(xinit));
      chk("grant",    int'(bus.grant),      int'(m_grant));
      chk("ready0",   int'(bus.req0_ready), int'(xr0));
      chk("ready1",   int'(bus.req1_ready), int'(xr1));

      if (bus.req0_ready && bus.req1_ready) n_both++;
      hs0 = v0 && bus.req0_ready;
      hs1 = v1 && bus.req1_ready;
      if (hs0) begin hs0_t = t; n_hs++; end
      if (hs1) begin hs1_t = t; n_hs++; end

      if (bus.e && !e_prev) begin e_len = 1; e_data.push_back(bus.lcd_data); end
      else if (bus.e) e_len++;
      else if (e_prev) e_hi_len.push_back(e_len);
      e_prev = bus.e;
      if (first_idle_t < 0 && !bus.busy) first_idle_t = t;
      if (init_done_t < 0 && bus.init_done) init_done_t = t;

      if (xr0 || xr1) begin
        w        = xr1;
        nw.start = t + 1;
        nw.rs    = w ? bus.req1_rs : bus.req0_rs;
        nw.data  = w ? bus.req1_data : bus.req0_data;
        nw.len   = wr_len(nw.rs, nw.data);
        mq.push_back(nw);
        idle_from = t + 1 + nw.len;
        m_grant   = w;
      end
      t++;
    end
  end

  task automatic drive();
    bus.req0_valid = pend0 && (!rnd_mode || $urandom_range(0, 4) != 0);
    bus.req1_valid = pend1 && (!rnd_mode || $urandom_range(0, 4) != 0);
    bus.req0_rs    = r0;
    bus.req0_data  = d0;
    bus.req1_rs    = r1;
    bus.req1_data  = d1;
  endtask

  task automatic new_byte(output bit r, output logic [7:0] d);
    if ($urandom_range(0, 7) == 0) begin
      r = 1'b0;
      d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    end else begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
    end
  endtask

  // One clock: retire accepted bytes, optionally create new ones, drive inputs
  task automatic step();
    @(posedge clk);
    #1;
    if (hs0) pend0 = 1'b0;
    if (hs1) pend1 = 1'b0;
    if (rnd_mode) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin new_byte(r0, d0); pend0 = 1'b1; end
      if (!pend1 && $urandom_range(0, 2) == 0) begin new_byte(r1, d1); pend1 = 1'b1; end
    end
    drive();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin step(); n++; end
    chk("wait_idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic wait_and_check_init(input string tag);
    logic [7:0] exp_cmd [4];
    int         exp_hi [4];
    int         n;
    exp_cmd = '{8'h38, 8'h0E, 8'h01, 8'h06};
    exp_hi  = '{8, 8, 26, 8};
    n = 0;
    while (first_idle_t < 0 && n < 300) begin step(); n++; end
    chk({tag, "_first_idle"}, first_idle_t, 90);
    chk({tag, "_init_done_t"}, init_done_t, 90);
    chk({tag, "_n_cmds"}, e_data.size(), 4);
    chk({tag, "_n_pulses"}, e_hi_len.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < e_data.size())   chk({tag, "_cmd"}, int'(e_data[i]), int'(exp_cmd[i]));
      if (i < e_hi_len.size()) chk({tag, "_e_len"}, e_hi_len[i], exp_hi[i]);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0d actual=running expected=finished", t);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0; rnd_mode = 1'b0;
    r0 = 1'b0; r1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    drive();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Power-up and init sequence
    wait_and_check_init("s1");

    // Lone requester 0, data write
    r0 = 1'b1; d0 = 8'h41; pend0 = 1'b1; drive();
    n = 0;
    while (pend0 && n < 50) begin step(); n++; end
    chk("s2_accept_t", hs0_t, 91);
    wait_idle();
    chk("s2_grant", int'(bus.grant), 0);
    chk("s2_e_len", e_hi_len[$], 8);
    chk("s2_e_data", int'(e_data[$]), 8'h41);

    // Contention with grant=0: requester 1 first, then requester 0
    r0 = 1'b1; d0 = 8'h30; r1 = 1'b1; d1 = 8'h31;
    pend0 = 1'b1; pend1 = 1'b1; drive();
    n = 0;
    while (pend1 && n < 50) begin step(); n++; end
    chk("s3_grant_after_req1", int'(bus.grant), 1);
    n = 0;
    while (pend0 && n < 50) begin step(); n++; end
    chk("s3_req1_first", int'(hs1_t < hs0_t), 1);
    chk("s3_gap", hs0_t - hs1_t, 11);
    chk("s3_both_ready", n_both, 0);
    wait_idle();

    // Clear command from requester 1 holds off requester 0
    r1 = 1'b0; d1 = 8'h01; r0 = 1'b1; d0 = 8'h42;
    pend0 = 1'b1; pend1 = 1'b1; drive();
    n = 0;
    while ((pend0 || pend1) && n < 120) begin step(); n++; end
    chk("s4_gap", hs0_t - hs1_t, 41);
    wait_idle();

    // Reset in the middle of a write
    r0 = 1'b1; d0 = 8'h55; pend0 = 1'b1; drive();
    n = 0;
    while (pend0 && n < 50) begin step(); n++; end
    repeat (5) begin @(posedge clk); #1; end
    chk("s5_e_before", int'(bus.e), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_e_async", int'(bus.e), 0);
    chk("s5_busy_async", int'(bus.busy), 1);
    chk("s5_data_async", int'(bus.lcd_data), 0);
    chk("s5_init_async", int'(bus.init_done), 0);
    step();
    step();
    rst_n = 1'b1;

    // Request offered during init and withdrawn before idle
    repeat (30) step();
    r0 = 1'b1; d0 = 8'h77; pend0 = 1'b1; drive();
    repeat (20) step();
    pend0 = 1'b0; drive();
    wait_and_check_init("s6");
    repeat (20) step();
    chk("s6_no_transfer", n_hs, 0);
    chk("s6_idle", int'(bus.busy), 0);

    // Randomized traffic from both requesters
    rnd_mode = 1'b1;
    repeat (1500) step();
    rnd_mode = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0; drive();
    repeat (60) step();
    chk("rnd_activity", int'(n_hs > 50), 1);
    chk("rnd_both_ready", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
